// File: rtl/udc_pkg.sv
// Shared types and widths for the up/down counter command path.
package udc_pkg;
   localparam int UDC_WIDTH = 16;
   localparam int UDC_GAP_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      WAIT = 2'd2
   } state_t;
endpackage

// File: rtl/udc_gap_timer.sv
// Loadable down-counter; tc marks the last idle cycle of an inter-step gap.
module udc_gap_timer
   import udc_pkg::*;
#(
   parameter int GAP_W = UDC_GAP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [GAP_W-1:0] load_val,
   input  logic             dec,
   output logic             tc
);

   logic [GAP_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - GAP_W'(1);
      end
   end

   assign tc = (cnt == GAP_W'(1));

endmodule

// File: rtl/udc_step_gen.sv
// Walks a mirror position toward an accepted target, emitting one enable/up
// strobe per count with a programmable idle gap between strobes.
module udc_step_gen
   import udc_pkg::*;
#(
   parameter int WIDTH = UDC_WIDTH,
   parameter int GAP_W = UDC_GAP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] target,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             enable,
   output logic             up,
   output logic [WIDTH-1:0] position,
   output logic             busy,
   output logic             done
);

   state_t           state;
   state_t           state_d;
   logic [WIDTH-1:0] tgt_q;
   logic [GAP_W-1:0] gap_q;
   logic [WIDTH-1:0] pos_step;
   logic             gap_load;
   logic             gap_tc;

   udc_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (gap_load),
      .load_val (gap_q),
      .dec      (state == WAIT),
      .tc       (gap_tc)
   );

   // up is fixed at accept: the direction never changes during one move
   assign pos_step = up ? position + WIDTH'(1) : position - WIDTH'(1);

   always_comb begin
      state_d  = state;
      gap_load = 1'b0;
      case (state)
         IDLE: begin
            if (tgt_valid && (target != position)) state_d = STEP;
         end
         STEP: begin
            if ((pos_step == tgt_q) || abort) begin
               state_d = IDLE;
            end else if (gap_q == '0) begin
               state_d = STEP;
            end else begin
               state_d  = WAIT;
               gap_load = 1'b1;
            end
         end
         WAIT: begin
            if (abort)       state_d = IDLE;
            else if (gap_tc) state_d = STEP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         enable    <= 1'b0;
         up        <= 1'b0;
         position  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         tgt_ready <= 1'b1;
      end else begin
         state     <= state_d;
         enable    <= (state_d == STEP);
         busy      <= (state_d != IDLE);
         tgt_ready <= (state_d == IDLE);
         done      <= 1'b0;
         if ((state == IDLE) && tgt_valid) begin
            up   <= (target > position);
            done <= (target == position);
         end
         if (state == STEP) position <= pos_step;
         if ((state != IDLE) && (state_d == IDLE)) done <= 1'b1;
      end
   end

   // Move parameters are plain data and need no reset
   always_ff @(posedge clk) begin
      if ((state == IDLE) && tgt_valid) begin
         tgt_q <= target;
         gap_q <= gap;
      end
   end

endmodule

// File: tb/tb_udc_step_gen.sv
// Randomized self-checking bench for udc_step_gen against a schedule model.
module tb_udc_step_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tgt_valid;
   logic        tgt_ready;
   logic [15:0] target;
   logic [7:0]  gap;
   logic        abort;
   logic        enable;
   logic        up;
   logic [15:0] position;
   logic        busy;
   logic        done;

   int          n_checks = 0;
   int          n_errors = 0;
   int          exp_pos  = 0;
   logic [15:0] ref_cnt;

   always #5 clk = ~clk;

   udc_step_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tgt_valid (tgt_valid),
      .tgt_ready (tgt_ready),
      .target    (target),
      .gap       (gap),
      .abort     (abort),
      .enable    (enable),
      .up        (up),
      .position  (position),
      .busy      (busy),
      .done      (done)
   );

   // Downstream up/down counter fed by the DUT strobes
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ref_cnt <= 16'd0;
      else if (enable) ref_cnt <= up ? ref_cnt + 16'd1 : ref_cnt - 16'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_enable"}, enable, 0);
      check({tag, "_up"}, up, 0);
      check({tag, "_position"}, position, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_ready"}, tgt_ready, 1);
      check({tag, "_counter"}, ref_cnt, 0);
   endtask

   // Called at a negedge with the DUT idle. amode: 0 none, 1 abort in the
   // first gap cycle after step an, 2 abort during step an. hold >= 0 keeps
   // tgt_valid high with that target throughout the move.
   task automatic move(input int t, input int g, input int amode, input int an, input int hold);
      int d, s, done_j, abort_j;
      logic exp_en, busy_exp;
      d = (t > exp_pos) ? t - exp_pos : exp_pos - t;
      s = (d == 0) ? 0 : ((amode != 0) ? an : d);
      if (s == 0) done_j = 1;
      else        done_j = (s - 1) * (g + 1) + 2 + ((amode == 1) ? 1 : 0);
      if (d == 0)          abort_j = -1;
      else if (amode == 1) abort_j = (an - 1) * (g + 1) + 2;
      else if (amode == 2) abort_j = (an - 1) * (g + 1) + 1;
      else                 abort_j = -1;
      tgt_valid = 1'b1;
      target    = 16'(t);
      gap       = 8'(g);
      abort     = 1'b0;
      for (int j = 1; j <= done_j; j++) begin
         @(negedge clk);
         tgt_valid = (hold >= 0);
         target    = (hold >= 0) ? 16'(hold) : 16'($urandom);
         gap       = 8'($urandom);
         abort     = (j == abort_j);
         exp_en    = (s > 0) && (((j - 1) % (g + 1)) == 0) && (((j - 1) / (g + 1)) < s);
         busy_exp  = (s > 0) && (j < done_j);
         check("enable", enable, exp_en);
         if (exp_en) check("up", up, (t > exp_pos));
         check("position", position, exp_pos);
         check("counter", ref_cnt, exp_pos);
         check("done", done, (j == done_j));
         check("busy", busy, busy_exp);
         check("ready", tgt_ready, !busy_exp);
         if (exp_en) exp_pos = (t > exp_pos) ? exp_pos + 1 : exp_pos - 1;
      end
      if (hold < 0) tgt_valid = 1'b0;
   endtask

   initial begin
      int t, g, d, am, an;
      rst_n     = 1'b0;
      tgt_valid = 1'b0;
      target    = 16'd0;
      gap       = 8'd0;
      abort     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("post_reset");

      move(5, 0, 0, 0, -1);
      check("pos_after_5", position, 5);
      move(2, 3, 0, 0, -1);
      move(2, 0, 0, 0, -1);
      move(100, 1, 1, 4, -1);
      check("pos_after_abort", position, 6);
      move(10, 0, 0, 0, 50);
      move(50, 0, 0, 0, -1);

      // abort while idle has no effect
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("idle_abort_busy", busy, 0);
      check("idle_abort_enable", enable, 0);
      check("idle_abort_done", done, 0);
      check("idle_abort_pos", position, 50);

      move(53, 2, 2, 3, -1);
      move(40, 0, 2, 2, -1);

      for (int k = 0; k < 40; k++) begin
         t = exp_pos + $urandom_range(0, 30) - 15;
         if (t < 0)  t = 0;
         if (t > 60) t = 60;
         g  = $urandom_range(0, 3);
         d  = (t > exp_pos) ? t - exp_pos : exp_pos - t;
         am = $urandom_range(0, 2);
         an = 0;
         if (am == 1 && (g == 0 || d < 2)) am = 0;
         if (am == 2 && d < 1) am = 0;
         if (am == 1) an = $urandom_range(1, d - 1);
         if (am == 2) an = $urandom_range(1, d);
         move(t, g, am, an, -1);
      end

      // Reset in the middle of a move at position 9
      move(0, 0, 0, 0, -1);
      tgt_valid = 1'b1;
      target    = 16'd20;
      gap       = 8'd0;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         tgt_valid = 1'b0;
      end
      check("pre_reset_pos", position, 9);
      check("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_reset");
      exp_pos = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("after_mid_reset");
      move(3, 1, 0, 0, -1);
      check("final_pos", position, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
